// File: rtl/cpu_pkg.sv
// Shared CPU types: writeback source select, load funct3 codes, writeback FSM states.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Reserved funct3 codes behave as LW, so they fall into the word check.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data aligner: picks byte/half/word from the raw aligned word and extends to XLEN.
// Purely combinational; reserved funct3 codes pass the word through like LW.
module writeback_stage_load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*addr_lo +: 8];
  assign half_sel = rdata[16*addr_lo[1] +: 16];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects result source, aligns load data, drives the register file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN; otherwise retire_count is tied to zero.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       write_data,
  output logic                  reg_write,
  output logic                  misalign_err,
  output logic [63:0]           retire_count
);

  wb_state_e             state;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr_lo;
  logic                  ld_reg_write;

  logic                  accept;
  logic                  is_load;
  logic                  misaligned;
  logic [XLEN-1:0]       wb_value;
  logic [XLEN-1:0]       load_value;

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign is_load    = (wb_sel_e'(in_wb_sel) == WB_MEM);
  assign misaligned = load_misaligned(in_funct3, in_alu_result[1:0]);

  always_comb begin
    wb_value = in_alu_result;
    case (wb_sel_e'(in_wb_sel))
      WB_PC4:  wb_value = in_pc_plus4;
      WB_IMM:  wb_value = in_imm;
      default: wb_value = in_alu_result;
    endcase
  end

  writeback_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (mem_rdata),
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .result  (load_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rd           <= '0;
      write_data   <= '0;
      reg_write    <= 1'b0;
      misalign_err <= 1'b0;
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_addr_lo   <= '0;
      ld_reg_write <= 1'b0;
    end else begin
      reg_write    <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_load) begin
              if (misaligned) begin
                misalign_err <= 1'b1;
              end else begin
                ld_rd        <= in_rd;
                ld_funct3    <= in_funct3;
                ld_addr_lo   <= in_alu_result[1:0];
                ld_reg_write <= in_reg_write;
                state        <= WAIT_MEM;
              end
            end else begin
              rd         <= in_rd;
              write_data <= wb_value;
              reg_write  <= in_reg_write && (in_rd != '0);
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            rd         <= ld_rd;
            write_data <= load_value;
            reg_write  <= ld_reg_write && (ld_rd != '0);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire_inc;

  // Loads retire on data arrival; everything else, including misaligned drops, at accept.
  assign retire_inc = (accept && (!is_load || misaligned)) ||
                      ((state == WAIT_MEM) && mem_rvalid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count <= 64'd0;
    end else if (retire_inc) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`else
  assign retire_count = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: source select, load alignment, misalign drop, x0 guard, reset abort, retire count.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic [31:0] in_imm = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        reg_write;
  logic        misalign_err;
  logic [63:0] retire_count;

  int total = 0;
  int bad = 0;

  writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_imm        (in_imm),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rd            (rd),
    .write_data    (write_data),
    .reg_write     (reg_write),
    .misalign_err  (misalign_err),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Unused sources get distinct filler so a wrong select shows up in write_data.
  task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rdi,
                       input logic rw, input logic [31:0] val);
    in_valid      = 1'b1;
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_rd         = rdi;
    in_reg_write  = rw;
    in_alu_result = (sel == 2'd0 || sel == 2'd1) ? val : 32'hA1A1_A1A1;
    in_pc_plus4   = (sel == 2'd2) ? val : 32'hB2B2_B2B2;
    in_imm        = (sel == 2'd3) ? val : 32'hC3C3_C3C3;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  // Accept a load, hold off nwait cycles (stray rvalid in the accept cycle), then deliver rdata.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] addr,
                         input logic [4:0] rdi, input logic [31:0] rdata, input int nwait);
    drive(2'd1, f3, rdi, 1'b1, {30'd0, addr});
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    step();
    idle_in();
    mem_rvalid = 1'b0;
    chk({tag, "_ready_wait0"}, in_ready, 1'b0);
    chk({tag, "_we_wait0"}, reg_write, 1'b0);
    for (int i = 1; i < nwait; i++) begin
      step();
      chk({tag, "_ready_wait"}, in_ready, 1'b0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    // reset
    #12;
    chk("rst_rd", rd, 5'd0);
    chk("rst_wd", write_data, 32'd0);
    chk("rst_we", reg_write, 1'b0);
    chk("rst_mis", misalign_err, 1'b0);
    chk("rst_cnt", retire_count, 64'd0);
    reset = 1'b1;
    step();
    chk("rst_ready", in_ready, 1'b1);

    // 1: back-to-back ALU then PC4
    drive(2'd0, 3'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    step();
    chk("t1_we0", reg_write, 1'b1);
    chk("t1_rd0", rd, 5'd5);
    chk("t1_wd0", write_data, 32'hDEAD_BEEF);
    chk("t1_ready", in_ready, 1'b1);
    drive(2'd2, 3'd0, 5'd1, 1'b1, 32'h0000_0104);
    step();
    idle_in();
    chk("t1_we1", reg_write, 1'b1);
    chk("t1_rd1", rd, 5'd1);
    chk("t1_wd1", write_data, 32'h0000_0104);
    step();
    chk("t1_we_idle", reg_write, 1'b0);
    chk("t1_wd_hold", write_data, 32'h0000_0104);

    // 2: LB / LBU at byte 3
    do_load("t2_lb", 3'd0, 2'd3, 5'd7, 32'h80FF_1234, 3);
    chk("t2_lb_we", reg_write, 1'b1);
    chk("t2_lb_rd", rd, 5'd7);
    chk("t2_lb_wd", write_data, 32'hFFFF_FF80);
    chk("t2_lb_ready", in_ready, 1'b1);
    do_load("t2_lbu", 3'd4, 2'd3, 5'd8, 32'h80FF_1234, 3);
    chk("t2_lbu_we", reg_write, 1'b1);
    chk("t2_lbu_wd", write_data, 32'h0000_0080);
    step();
    chk("t2_we_idle", reg_write, 1'b0);

    // 3: LH upper half, then misaligned LHU
    do_load("t3_lh", 3'd1, 2'd2, 5'd9, 32'h8001_0000, 1);
    chk("t3_lh_wd", write_data, 32'hFFFF_8001);
    chk("t3_lh_we", reg_write, 1'b1);
    drive(2'd1, 3'd5, 5'd10, 1'b1, 32'h0000_0001);
    step();
    idle_in();
    chk("t3_mis", misalign_err, 1'b1);
    chk("t3_mis_we", reg_write, 1'b0);
    chk("t3_mis_ready", in_ready, 1'b1);
    chk("t3_mis_wd_hold", write_data, 32'hFFFF_8001);
    step();
    chk("t3_mis_pulse", misalign_err, 1'b0);

    // 4: IMM to x0
    drive(2'd3, 3'd0, 5'd0, 1'b1, 32'h1234_5000);
    step();
    idle_in();
    chk("t4_we", reg_write, 1'b0);
    chk("t4_wd", write_data, 32'h1234_5000);
    chk("t4_rd", rd, 5'd0);

    // 5: reset while a load is pending
    drive(2'd1, 3'd2, 5'd12, 1'b1, 32'h0000_0000);
    step();
    idle_in();
    chk("t5_wait", in_ready, 1'b0);
    step();
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_wd", write_data, 32'd0);
    chk("t5_rst_rd", rd, 5'd0);
    chk("t5_rst_we", reg_write, 1'b0);
    chk("t5_rst_cnt", retire_count, 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("t5_ready", in_ready, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk("t5_late_we", reg_write, 1'b0);
    chk("t5_late_wd", write_data, 32'd0);
    chk("t5_late_ready", in_ready, 1'b1);

    // 6: ten mixed instructions
    drive(2'd0, 3'd0, 5'd3, 1'b1, 32'h0000_0011);
    step();
    chk("t6_alu_wd", write_data, 32'h0000_0011);
    drive(2'd0, 3'd0, 5'd0, 1'b1, 32'h0000_0022);
    step();
    chk("t6_x0_we", reg_write, 1'b0);
    drive(2'd0, 3'd0, 5'd4, 1'b0, 32'h0000_0033);
    step();
    chk("t6_norw_we", reg_write, 1'b0);
    chk("t6_norw_wd", write_data, 32'h0000_0033);
    drive(2'd3, 3'd0, 5'd6, 1'b1, 32'hABCD_E000);
    step();
    chk("t6_imm_wd", write_data, 32'hABCD_E000);
    drive(2'd2, 3'd0, 5'd2, 1'b1, 32'h0000_2008);
    step();
    chk("t6_pc4_wd", write_data, 32'h0000_2008);
    drive(2'd1, 3'd2, 5'd11, 1'b1, 32'h0000_0002);
    step();
    idle_in();
    chk("t6_lw_mis", misalign_err, 1'b1);
    do_load("t6_rsv", 3'd3, 2'd0, 5'd13, 32'hCAFE_F00D, 2);
    chk("t6_rsv_wd", write_data, 32'hCAFE_F00D);
    do_load("t6_lhu", 3'd5, 2'd2, 5'd14, 32'h8001_1234, 1);
    chk("t6_lhu_wd", write_data, 32'h0000_8001);
    do_load("t6_lb", 3'd0, 2'd1, 5'd15, 32'h0000_7F00, 2);
    chk("t6_lb_wd", write_data, 32'h0000_007F);
    drive(2'd0, 3'd0, 5'd9, 1'b1, 32'h0000_0099);
    step();
    idle_in();
    chk("t6_last_rd", rd, 5'd9);
    step();
`ifdef WB_RETIRE_CNT_EN
    chk("t6_retire", retire_count, 64'd10);
`else
    chk("t6_retire", retire_count, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
